// File: rtl/vga_pkg.sv
// Shared timing defaults, derived totals and types for the VGA raster generator.
package vga_pkg;

    // 640x480@60 timing, 100 MHz system clock
    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_PIX_LAT  = 1;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Raster counters are 10 bit; decode compares run one bit wider so
    // limits such as H_TOTAL=800 never wrap.
    localparam int unsigned CNT_W = 10;
    localparam int unsigned CMP_W = 11;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '0;

    // Per-pixel region flags carried through the latency-matching delay line
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } flags_t;

    localparam int unsigned FLAG_W = $bits(flags_t);

    // Half-open interval test: lo <= v < hi
    function automatic logic in_span(
        input logic [CMP_W-1:0] v,
        input logic [CMP_W-1:0] lo,
        input logic [CMP_W-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register; each enabled clock moves data one stage along.
// DEPTH=0 collapses to a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ctrl;
            assign w_unused_ctrl = &{1'b0, clk, reset_n, en};
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift on enable; reset clears every stage
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (en) begin
                    r_stage[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate divider, DrawX/DrawY counters, region
// decode, renderer-latency alignment and registered VGA pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIX_LAT  = DEF_PIX_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       Red_in,
    input  logic [3:0]       Green_in,
    input  logic [3:0]       Blue_in,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             pixel_tick,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOT - 1);

    localparam logic [CMP_W-1:0] H_ACT_C = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_ACT_C = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_LO   = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_HI   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_LO   = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_HI   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [CNT_W-1:0]  r_draw_x;
    logic [CNT_W-1:0]  r_draw_y;
    logic [CNT_W-1:0]  w_x_next;
    logic [CNT_W-1:0]  w_y_next;
    logic              w_pixel_tick;
    logic              w_x_last;
    logic              w_y_last;
    logic [CMP_W-1:0]  w_x_cmp;
    logic [CMP_W-1:0]  w_y_cmp;
    flags_t            w_raw;
    logic [FLAG_W-1:0] w_dly_q;
    flags_t            w_dly;
    rgb_t              w_rgb_in;
    rgb_t              r_rgb;
    logic              r_active;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_frame_start;

    // System-clock divider: wraps every CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_pixel_tick = (r_div_cnt == DIV_LAST);
    assign w_x_last     = (r_draw_x == X_LAST);
    assign w_y_last     = (r_draw_y == Y_LAST);

    // Next raster position: advance on the pixel tick, wrap line then frame
    always_comb begin
        w_x_next = r_draw_x;
        w_y_next = r_draw_y;
        if (w_pixel_tick) begin
            if (w_x_last) begin
                w_x_next = '0;
                w_y_next = w_y_last ? '0 : r_draw_y + 1'b1;
            end else begin
                w_x_next = r_draw_x + 1'b1;
            end
        end
    end

    // Raster position registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_draw_x <= '0;
            r_draw_y <= '0;
        end else begin
            r_draw_x <= w_x_next;
            r_draw_y <= w_y_next;
        end
    end

    // Frame pulse marks the first clock spent at (0,0) after a wrap, so it
    // never fires on reset release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pixel_tick && w_x_last && w_y_last;
        end
    end

    assign w_x_cmp = {1'b0, r_draw_x};
    assign w_y_cmp = {1'b0, r_draw_y};

    // Region decode for the pixel currently being issued to the renderer
    always_comb begin
        w_raw     = '0;
        w_raw.act = (w_x_cmp < H_ACT_C) && (w_y_cmp < V_ACT_C);
        w_raw.hs  = in_span(w_x_cmp, HS_LO, HS_HI);
        w_raw.vs  = in_span(w_y_cmp, VS_LO, VS_HI);
    end

    // Hold the flags back by the renderer latency so they line up with RGB
    vga_delay_line #(
        .WIDTH (FLAG_W),
        .DEPTH (PIX_LAT)
    ) u_flag_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_pixel_tick),
        .d       (w_raw),
        .q       (w_dly_q)
    );

    assign w_dly    = flags_t'(w_dly_q);
    assign w_rgb_in = {Red_in, Green_in, Blue_in};

    // Pin register: sync polarity applied here, colour blanked outside active
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_rgb    <= RGB_BLACK;
        end else if (w_pixel_tick) begin
            r_active <= w_dly.act;
            r_hsync  <= w_dly.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync  <= w_dly.vs ? SYNC_POL : ~SYNC_POL;
            r_rgb    <= w_dly.act ? w_rgb_in : RGB_BLACK;
        end
    end

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign pixel_tick  = w_pixel_tick;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one default-timing instance plus three
// reduced-timing instances (PIX_LAT 1, 0, 3) sharing clock and reset.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] dx  [4];
    logic [9:0] dy  [4];
    logic       tick[4];
    logic       fs  [4];
    logic       hs  [4];
    logic       vs  [4];
    logic       act [4];
    logic [3:0] vr  [4];
    logic [3:0] vg  [4];
    logic [3:0] vb  [4];
    logic [3:0] rin [4];
    logic [3:0] gin [4];
    logic [3:0] bin [4];

    int unsigned c;          // clocks since last reset release
    int unsigned nvec;
    int unsigned nerr;
    int unsigned fs_cnt[4];
    int unsigned fs_c1 [4];
    int unsigned fs_c2 [4];

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .reset_n(reset_n),
        .Red_in(rin[0]), .Green_in(gin[0]), .Blue_in(bin[0]),
        .DrawX(dx[0]), .DrawY(dy[0]), .pixel_tick(tick[0]), .frame_start(fs[0]),
        .hsync(hs[0]), .vsync(vs[0]), .active(act[0]),
        .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(1)
    ) u_b (
        .clk(clk), .reset_n(reset_n),
        .Red_in(rin[1]), .Green_in(gin[1]), .Blue_in(bin[1]),
        .DrawX(dx[1]), .DrawY(dy[1]), .pixel_tick(tick[1]), .frame_start(fs[1]),
        .hsync(hs[1]), .vsync(vs[1]), .active(act[1]),
        .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(0)
    ) u_c (
        .clk(clk), .reset_n(reset_n),
        .Red_in(rin[2]), .Green_in(gin[2]), .Blue_in(bin[2]),
        .DrawX(dx[2]), .DrawY(dy[2]), .pixel_tick(tick[2]), .frame_start(fs[2]),
        .hsync(hs[2]), .vsync(vs[2]), .active(act[2]),
        .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2])
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_LAT(3)
    ) u_d (
        .clk(clk), .reset_n(reset_n),
        .Red_in(rin[3]), .Green_in(gin[3]), .Blue_in(bin[3]),
        .DrawX(dx[3]), .DrawY(dy[3]), .pixel_tick(tick[3]), .frame_start(fs[3]),
        .hsync(hs[3]), .vsync(vs[3]), .active(act[3]),
        .vga_r(vr[3]), .vga_g(vg[3]), .vga_b(vb[3])
    );

    // Renderer colour as a function of the pixel's X position
    function automatic logic [11:0] col(input int unsigned x);
        logic [9:0] xv;
        xv = 10'(x);
        return {xv[3:0] ^ 4'h9, xv[7:4] ^ 4'h6, ~xv[3:0]};
    endfunction

    // Model of a renderer with latency lat: presents the colour of the pixel
    // issued lat ticks ago, derived from the bench's own clock count.
    task automatic drive_one(input int idx, input int unsigned htot, input int unsigned lat);
        int unsigned p;
        int unsigned x;
        p = c / 4;
        x = (p >= lat) ? (p - lat) % htot : 0;
        {rin[idx], gin[idx], bin[idx]} = col(x);
    endtask

    task automatic drive();
        drive_one(0, 800, 1);
        drive_one(1, 80, 1);
        drive_one(2, 80, 0);
        drive_one(3, 80, 3);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c++;
        for (int i = 0; i < 4; i++) begin
            if (fs[i] === 1'b1) begin
                fs_cnt[i]++;
                if (fs_cnt[i] == 1) fs_c1[i] = c;
                else fs_c2[i] = c;
            end
        end
        drive();
    endtask

    task automatic goto_c(input int unsigned t);
        while (c < t) step();
    endtask

    task automatic clear_fs();
        for (int i = 0; i < 4; i++) begin
            fs_cnt[i] = 0;
            fs_c1[i]  = 0;
            fs_c2[i]  = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_first, hs_last, vs_first, vs_last;
        int unsigned hs_cnt, act_cnt, blank_bad, xbad, ybad, vs_cnt;
        int first_hs[4], first_act[4], last_act[4], first_vs[4];

        nvec = 0; nerr = 0; c = 0;
        clear_fs();
        hs_first = -1; hs_last = -1; vs_first = -1; vs_last = -1;
        hs_cnt = 0; act_cnt = 0; blank_bad = 0; xbad = 0; ybad = 0; vs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            first_hs[i] = -1; first_act[i] = -1; last_act[i] = -1; first_vs[i] = -1;
        end

        // Step 1: reset held 10 clocks, then released
        reset_n = 1'b0;
        drive();
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b1;
        c = 0;
        drive();
        check("rst_x",    32'(dx[0]), 32'd0);
        check("rst_y",    32'(dy[0]), 32'd0);
        check("rst_hs",   32'(hs[0]), 32'd1);
        check("rst_vs",   32'(vs[0]), 32'd1);
        check("rst_act",  32'(act[0]), 32'd0);
        check("rst_rgb",  32'({vr[0], vg[0], vb[0]}), 32'd0);
        check("rst_fs",   32'(fs[0]), 32'd0);
        check("rst_tick", 32'(tick[0]), 32'd0);

        // Step 2: first pixel tick lands on the 4th clock after release
        goto_c(2);
        check("tick_c2", 32'(tick[0]), 32'd0);
        goto_c(3);
        check("tick_c3", 32'(tick[0]), 32'd1);
        check("x_hold",  32'(dx[0]), 32'd0);
        goto_c(4);
        check("tick_c4", 32'(tick[0]), 32'd0);
        check("x_adv",   32'(dx[0]), 32'd1);

        // Step 3: one full line on the default instance
        for (int unsigned p = 1; p <= 800; p++) begin
            goto_c(4 * p + 2);
            if (dx[0] !== 10'(p % 800)) xbad++;
            if (dy[0] !== 10'(p / 800)) ybad++;
            if (p < 800) begin
                if (hs[0] === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(p);
                    hs_last = int'(p);
                end
                if (act[0] === 1'b1) act_cnt++;
                if (act[0] !== 1'b1 && {vr[0], vg[0], vb[0]} !== 12'h000) blank_bad++;
            end
            if (p < 80) begin
                for (int i = 1; i < 4; i++) begin
                    if (hs[i] === 1'b0 && first_hs[i] < 0) first_hs[i] = int'(p);
                    if (act[i] === 1'b1) begin
                        if (first_act[i] < 0) first_act[i] = int'(p);
                        last_act[i] = int'(p);
                    end
                end
            end
            if (p == 10) begin
                check("rgb_a_p10", 32'({vr[0], vg[0], vb[0]}), 32'h167);
                check("rgb_b_p10", 32'({vr[1], vg[1], vb[1]}), 32'h167);
                check("rgb_c_p10", 32'({vr[2], vg[2], vb[2]}), 32'h066);
                check("rgb_d_p10", 32'({vr[3], vg[3], vb[3]}), 32'hF69);
            end
            if (p == 82) check("rgb_b_p82", 32'({vr[1], vg[1], vb[1]}), 32'h96F);
            if (p == 700) check("rgb_a_blank", 32'({vr[0], vg[0], vb[0]}), 32'h000);
        end
        check("line_x_seq",    32'(xbad), 32'd0);
        check("line_y_seq",    32'(ybad), 32'd0);
        check("line_end_x",    32'(dx[0]), 32'd0);
        check("line_end_y",    32'(dy[0]), 32'd1);
        check("hs_low_ticks",  32'(hs_cnt), 32'd96);
        check("hs_first_low",  32'(hs_first), 32'd658);
        check("hs_last_low",   32'(hs_last), 32'd753);
        check("act_ticks",     32'(act_cnt), 32'd640);
        check("blank_rgb",     32'(blank_bad), 32'd0);
        check("hs_first_b",    32'(first_hs[1]), 32'd70);
        check("hs_first_c",    32'(first_hs[2]), 32'd69);
        check("hs_first_d",    32'(first_hs[3]), 32'd72);
        check("act_first_b",   32'(first_act[1]), 32'd2);
        check("act_first_c",   32'(first_act[2]), 32'd1);
        check("act_first_d",   32'(first_act[3]), 32'd4);
        check("act_last_b",    32'(last_act[1]), 32'd65);
        check("act_last_c",    32'(last_act[2]), 32'd64);
        check("act_last_d",    32'(last_act[3]), 32'd67);

        // Step 4: rest of the first reduced frame, vertical sync placement
        for (int unsigned p = 801; p < 4400; p++) begin
            goto_c(4 * p + 2);
            if (vs[1] === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(p);
                vs_last = int'(p);
            end
            for (int i = 2; i < 4; i++) begin
                if (vs[i] === 1'b0 && first_vs[i] < 0) first_vs[i] = int'(p);
            end
            if (p == 3850) check("rgb_b_vblank", 32'({vr[1], vg[1], vb[1]}), 32'h000);
            if (p == 4399) begin
                check("a_x_p4399", 32'(dx[0]), 32'd399);
                check("a_y_p4399", 32'(dy[0]), 32'd5);
                check("b_x_p4399", 32'(dx[1]), 32'd79);
                check("b_y_p4399", 32'(dy[1]), 32'd54);
            end
        end
        check("vs_low_ticks", 32'(vs_cnt), 32'd160);
        check("vs_first_b",   32'(vs_first), 32'd4002);
        check("vs_last_b",    32'(vs_last), 32'd4161);
        check("vs_first_c",   32'(first_vs[2]), 32'd4001);
        check("vs_first_d",   32'(first_vs[3]), 32'd4004);

        // Step 5: frame_start cadence over two reduced frames
        goto_c(36000);
        check("fs_cnt_a",  32'(fs_cnt[0]), 32'd0);
        check("fs_cnt_b",  32'(fs_cnt[1]), 32'd2);
        check("fs_c1_b",   32'(fs_c1[1]), 32'd17600);
        check("fs_c2_b",   32'(fs_c2[1]), 32'd35200);
        check("fs_cnt_d",  32'(fs_cnt[3]), 32'd2);
        check("fs_c1_d",   32'(fs_c1[3]), 32'd17600);

        // Step 6: one-clock reset in the middle of a frame
        goto_c(4 * 10430 + 2);
        check("pre_x_b",   32'(dx[1]), 32'd30);
        check("pre_y_b",   32'(dy[1]), 32'd20);
        check("pre_act_b", 32'(act[1]), 32'd1);
        check("pre_rgb_b", 32'({vr[1], vg[1], vb[1]}), 32'h573);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        c = 0;
        clear_fs();
        drive();
        check("mid_x_b",   32'(dx[1]), 32'd0);
        check("mid_y_b",   32'(dy[1]), 32'd0);
        check("mid_hs_b",  32'(hs[1]), 32'd1);
        check("mid_vs_b",  32'(vs[1]), 32'd1);
        check("mid_act_b", 32'(act[1]), 32'd0);
        check("mid_rgb_b", 32'({vr[1], vg[1], vb[1]}), 32'h000);
        check("mid_fs_b",  32'(fs[1]), 32'd0);
        check("mid_x_a",   32'(dx[0]), 32'd0);

        // Step 7: raster restarts cleanly after the mid-frame reset
        first_hs[1] = -1;
        for (int unsigned p = 1; p <= 100; p++) begin
            goto_c(4 * p + 2);
            if (hs[1] === 1'b0 && first_hs[1] < 0) first_hs[1] = int'(p);
            if (p == 1) check("rs_act_b_p1", 32'(act[1]), 32'd0);
            if (p == 5) check("rs_x_b_p5", 32'(dx[1]), 32'd5);
            if (p == 82) check("rs_rgb_b_p82", 32'({vr[1], vg[1], vb[1]}), 32'h96F);
        end
        check("rs_hs_first_b", 32'(first_hs[1]), 32'd70);
        check("rs_y_b",        32'(dy[1]), 32'd1);
        check("rs_fs_cnt_b",   32'(fs_cnt[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
